// File: rtl/wide_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_sequencer_if
// Description : Operand/result handshake bundle for the multi-limb adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int c_W = 64 * WORDS;

    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] in_a;
    logic [c_W-1:0] in_b;
    logic           in_cin;
    logic           in_sub;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] out_sum;
    logic           out_cout;
    logic           out_ovf;
    logic           busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_limb / wide_add_sequencer
// Description : Multi-limb add/subtract, one 64-bit limb per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================

module wide_add_limb (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] s_o,
    output logic        cout_o
);
    logic [64:0] w_sum;

    assign w_sum  = {1'b0, a_i} + {1'b0, b_i} + {64'd0, cin_i};
    assign s_o    = w_sum[63:0];
    assign cout_o = w_sum[64];
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);
    localparam int              c_W    = 64 * WORDS;
    localparam int              c_KW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [c_W-1:0]  a_q, a_d;
    logic [c_W-1:0]  b_q, b_d;
    logic [c_W-1:0]  sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [c_KW-1:0] k_q, k_d;

    logic            w_accept;
    logic            w_last;
    logic [c_KW+5:0] w_base;
    logic [c_W-1:0]  w_a_shift;
    logic [c_W-1:0]  w_b_shift;
    logic [c_W-1:0]  w_mask;
    logic [c_W-1:0]  w_ins;
    logic [63:0]     w_a_limb;
    logic [63:0]     w_b_limb;
    logic [63:0]     w_s;
    logic            w_c;

    assign w_accept = (state_q == c_IDLE) && bus.in_valid;
    assign w_last   = (state_q == c_RUN) && (k_q == c_LAST);

    // Limb selection by shifting keeps the select width independent of WORDS.
    assign w_base    = {k_q, 6'b000000};
    assign w_a_shift = a_q >> w_base;
    assign w_b_shift = b_q >> w_base;
    assign w_a_limb  = w_a_shift[63:0];
    assign w_b_limb  = w_b_shift[63:0];
    assign w_mask    = c_W'(64'hFFFF_FFFF_FFFF_FFFF) << w_base;
    assign w_ins     = c_W'(w_s) << w_base;

    wide_add_limb u_limb (
        .a_i    (w_a_limb),
        .b_i    (w_b_limb),
        .cin_i  (carry_q),
        .s_o    (w_s),
        .cout_o (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (bus.in_valid)  state_d = c_RUN;
            c_RUN:   if (w_last)        state_d = c_DONE;
            c_DONE:  if (bus.out_ready) state_d = c_IDLE;
            default:                    state_d = c_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == c_IDLE);
        bus.busy      = (state_q != c_IDLE);
        bus.out_valid = (state_q == c_DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        if (w_accept) begin
            // Subtraction is A + ~B + ~borrow; sum_q deliberately keeps the old result.
            a_d     = bus.in_a;
            b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_d = bus.in_sub ^ bus.in_cin;
            k_d     = '0;
        end else if (state_q == c_RUN) begin
            sum_d   = (sum_q & ~w_mask) | w_ins;
            carry_d = w_c;
            if (w_last) begin
                cout_d = w_c;
                ovf_d  = (a_q[c_W-1] == b_q[c_W-1]) && (w_s[63] != a_q[c_W-1]);
            end else begin
                k_d = k_q + c_KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;
    assign bus.out_ovf  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_sequencer
// Description : Self-checking bench for wide_add_sequencer (WORDS=4 and WORDS=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wide_add_sequencer_if #(.WORDS(4)) bus4 ();
    wide_add_sequencer_if #(.WORDS(1)) bus1 ();

    wide_add_sequencer #(.WORDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    wide_add_sequencer #(.WORDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic [255:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic         cin;
        logic         sub;
        logic [255:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [255:0] a, input logic [255:0] b,
                                   input logic cin, input logic sub);
        logic [255:0] bb;
        logic [256:0] r;
        exp_t         e;
        bb     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {256'd0, (sub ? ~cin : cin)};
        e.sum  = r[255:0];
        e.cout = r[256];
        e.ovf  = (a[255] == bb[255]) && (r[255] != a[255]);
        return e;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Results are compared only on the output handshake.
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum %0h with empty scoreboard", bus4.out_sum);
            end else begin
                mon_e = sb.pop_front();
                check("sum",  bus4.out_sum,  mon_e.sum);
                check("cout", {255'd0, bus4.out_cout}, {255'd0, mon_e.cout});
                check("ovf",  {255'd0, bus4.out_ovf},  {255'd0, mon_e.ovf});
            end
        end
    end

    task automatic send4(input logic [255:0] a, input logic [255:0] b,
                         input logic cin, input logic sub);
        bus4.in_a     = a;
        bus4.in_b     = b;
        bus4.in_cin   = cin;
        bus4.in_sub   = sub;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.in_a     = rand256();
        bus4.in_b     = rand256();
        bus4.in_cin   = ~cin;
        bus4.in_sub   = ~sub;
    endtask

    task automatic wait_valid4(output int n);
        n = 0;
        while (!bus4.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while (!bus4.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus4.in_ready) check("idle_timeout", 256'd0, 256'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int           n;
        logic         seen;
        logic [255:0] ra, rb;
        logic [63:0]  a1 [2];
        logic [63:0]  s1 [2];
        logic         c1 [2];
        logic         o1 [2];
        exp_t         e;

        vecs[0] = '{a: '1, b: 256'd1, cin: 0, sub: 0, sum: 256'd0, cout: 1, ovf: 0};
        vecs[1] = '{a: 256'hFFFF_FFFF_FFFF_FFFF, b: 256'd1, cin: 0, sub: 0,
                    sum: 256'h1_0000_0000_0000_0000, cout: 0, ovf: 0};
        vecs[2] = '{a: 256'd5, b: 256'd7, cin: 0, sub: 1, sum: ~256'd1, cout: 0, ovf: 0};
        vecs[3] = '{a: 256'd7, b: 256'd5, cin: 1, sub: 1, sum: 256'd1, cout: 1, ovf: 0};
        vecs[4] = '{a: {1'b0, {255{1'b1}}}, b: 256'd1, cin: 0, sub: 0,
                    sum: {1'b1, 255'd0}, cout: 0, ovf: 1};
        vecs[5] = '{a: 256'd0, b: 256'd0, cin: 1, sub: 0, sum: 256'd1, cout: 0, ovf: 0};
        vecs[6] = '{a: {1'b1, 255'd0}, b: 256'd1, cin: 0, sub: 1,
                    sum: {1'b0, {255{1'b1}}}, cout: 1, ovf: 1};
        vecs[7] = '{a: 256'd0, b: 256'd0, cin: 0, sub: 1, sum: 256'd0, cout: 1, ovf: 0};

        bus4.in_valid = 0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 0; bus4.in_sub = 0;
        bus4.out_ready = 0;
        bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 0; bus1.in_sub = 0;
        bus1.out_ready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {255'd0, bus4.out_valid}, 256'd0);
        check("rst_in_ready",  {255'd0, bus4.in_ready},  256'd1);
        check("rst_busy",      {255'd0, bus4.busy},      256'd0);
        check("rst_sum",       bus4.out_sum, 256'd0);
        check("rst_cout_ovf",  {254'd0, bus4.out_cout, bus4.out_ovf}, 256'd0);
        check("rst1_sum",      {192'd0, bus1.out_sum}, 256'd0);
        check("rst1_in_ready", {255'd0, bus1.in_ready}, 256'd1);
        @(posedge clk);
        #1;
        rst = 0;
        bus4.out_ready = 1;
        bus1.out_ready = 1;

        for (int i = 0; i < 8; i++) begin
            sb.push_back('{sum: vecs[i].sum, cout: vecs[i].cout, ovf: vecs[i].ovf});
            send4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_valid4(n);
            check("latency", n, 256'd4);
            wait_idle4();
        end

        for (int i = 0; i < 6; i++) begin
            ra = rand256();
            rb = (i == 0) ? ~ra : rand256();
            e  = model(ra, rb, 1'($urandom_range(0, 1)), 1'(i % 2));
            sb.push_back(model(ra, rb, e.cout, 1'(i % 2)));
            send4(ra, rb, e.cout, 1'(i % 2));
            wait_idle4();
        end

        // Backpressure with a stray request while the result is held.
        bus4.out_ready = 0;
        ra = rand256();
        rb = rand256();
        e  = model(ra, rb, 1'b1, 1'b0);
        sb.push_back(e);
        send4(ra, rb, 1'b1, 1'b0);
        wait_valid4(n);
        check("bp_latency", n, 256'd4);
        for (int c = 0; c < 10; c++) begin
            bus4.in_valid = (c == 3);
            bus4.in_a     = rand256();
            bus4.in_b     = rand256();
            @(negedge clk);
            check("bp_valid", {255'd0, bus4.out_valid}, 256'd1);
            check("bp_ready", {255'd0, bus4.in_ready},  256'd0);
            check("bp_sum",   bus4.out_sum, e.sum);
            check("bp_cout",  {255'd0, bus4.out_cout}, {255'd0, e.cout});
            @(posedge clk);
            #1;
        end
        bus4.in_valid  = 0;
        bus4.out_ready = 1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {255'd0, bus4.out_valid}, 256'd0);
        check("bp_release_ready", {255'd0, bus4.in_ready},  256'd1);

        // Abort during RUN at k=2.
        send4(rand256(), rand256(), 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("abort_valid", {255'd0, bus4.out_valid}, 256'd0);
        check("abort_ready", {255'd0, bus4.in_ready},  256'd1);
        check("abort_busy",  {255'd0, bus4.busy},      256'd0);
        check("abort_sum",   bus4.out_sum, 256'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus4.out_valid) seen = 1;
        end
        check("abort_no_result", {255'd0, seen}, 256'd0);
        @(posedge clk);
        #1;

        // Abort while a result is pending in DONE.
        bus4.out_ready = 0;
        send4(vecs[0].a, vecs[0].b, 1'b0, 1'b0);
        wait_valid4(n);
        check("done_valid", {255'd0, bus4.out_valid}, 256'd1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        bus4.out_ready = 1;
        check("done_abort_valid", {255'd0, bus4.out_valid}, 256'd0);
        check("done_abort_cout",  {255'd0, bus4.out_cout},  256'd0);

        e = model(vecs[4].a, vecs[6].a, 1'b1, 1'b1);
        sb.push_back(e);
        send4(vecs[4].a, vecs[6].a, 1'b1, 1'b1);
        wait_idle4();

        a1[0] = 64'hFFFF_FFFF_FFFF_FFFF; s1[0] = 64'd0;                  c1[0] = 1; o1[0] = 0;
        a1[1] = 64'h7FFF_FFFF_FFFF_FFFF; s1[1] = 64'h8000_0000_0000_0000; c1[1] = 0; o1[1] = 1;
        for (int i = 0; i < 2; i++) begin
            bus1.in_a = a1[i]; bus1.in_b = 64'd1; bus1.in_cin = 0; bus1.in_sub = 0;
            bus1.in_valid = 1;
            @(posedge clk);
            #1;
            bus1.in_valid = 0;
            n = 0;
            while (!bus1.out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("w1_latency", n, 256'd1);
            check("w1_sum",  {192'd0, bus1.out_sum}, {192'd0, s1[i]});
            check("w1_cout", {255'd0, bus1.out_cout}, {255'd0, c1[i]});
            check("w1_ovf",  {255'd0, bus1.out_ovf},  {255'd0, o1[i]});
            repeat (2) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drain", sb.size(), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-limb adder/subtractor for operands wider than 64 bits, for example 256-bit.
- Processes one 64-bit limb per clock, least-significant limb first.
- Uses a single 64-bit add-with-carry datapath and a registered inter-limb carry.
- Sits directly upstream of the result consumer. Provides valid/ready handshakes on both the operand side and the result side.

Parameters:
- WORDS, 4, number of 64-bit limbs per operand; total width W = 64*WORDS; legal range 1..16.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in when in_sub=0; borrow-in when in_sub=1.
- in_sub  input  1  0 computes A+B+cin; 1 computes A-B-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W  result modulo 2^W.
- out_cout  output  1  carry-out of the MSB; for subtract, 1 means no borrow.
- out_ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: state=IDLE, limb counter k=0, carry=0. Outputs: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=1.
- Reset in any state, including mid-RUN or DONE with out_valid=1, aborts the operation. No result is produced. Reset has priority over all handshakes.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready the block latches A into a_reg.
  - It latches B into b_reg, inverted when in_sub=1.
  - carry <= in_sub ? ~in_cin : in_cin.
  - k <= 0; go to RUN.
  - The sum register is not cleared on accept; out_sum still shows the previous result until overwritten.
- RUN, each cycle:
  - {c, s} = a_reg[64k+:64] + b_reg[64k+:64] + carry, computed as a 65-bit add.
  - sum_reg[64k+:64] <= s; carry <= c.
  - If k==WORDS-1: go to DONE, out_valid<=1, out_cout<=c.
  - Also on that last limb: out_ovf <= (a_msb == b'_msb) & (s[63] != a_msb). Here b'_msb is the MSB of the inverted-or-not B as held in b_reg.
  - Otherwise k <= k+1.
- Latency: with accept at edge T, out_valid rises at edge T+WORDS. For WORDS=1, that is 1 cycle after accept.
- DONE:
  - out_valid=1. out_sum, out_cout and out_ovf are held stable until handshake.
  - On out_ready: out_valid<=0, go to IDLE. in_ready becomes 1 the following cycle.
  - There is no same-cycle turnaround. Minimum request spacing is WORDS+2 cycles.
- Inputs are ignored whenever in_ready=0. in_a and in_b need not be held after accept.
- out_ready is ignored when out_valid=0.
- k uses clog2(WORDS) bits, minimum 1. It never exceeds WORDS-1, so there is no wrap-around past the last limb.
- Arithmetic is unsigned modulo 2^W. out_ovf is valid for both add and subtract.
- The 64-bit limb adder must be exact for all inputs, including full carry propagation across all 64 bits. It must be verified standalone before integration.

Test Plan:
- Ripple across all limbs: WORDS=4, A=2^256-1, B=1, cin=0, sub=0 → out_sum=0, out_cout=1, out_ovf=0. out_valid rises exactly 4 cycles after accept.
- Inter-limb carry: A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1 → out_sum=2^64 (limb1=1, others 0), out_cout=0.
- Subtract:
  - A=5, B=7, sub=1, cin=0 → out_sum=2^256-2, out_cout=0, out_ovf=0.
  - A=7, B=5, sub=1, cin=1 → out_sum=1, out_cout=1.
- Signed overflow: A=2^255-1, B=1, add → out_sum=2^255, out_ovf=1, out_cout=0.
- Backpressure: hold out_ready=0 for 10 cycles and pulse in_valid with new operands → out_valid, out_sum and out_cout stay stable; in_ready=0; new operands are ignored. Then raise out_ready → out_valid falls next edge; in_ready=1 one cycle later.
- Reset and minimum config:
  - Assert rst during RUN at k=2 → next cycle state=IDLE, out_valid=0, in_ready=1, and no result is ever emitted for that request.
  - WORDS=1 build with A=0xFFFF_FFFF_FFFF_FFFF, B=1 → out_sum=0, out_cout=1, 1-cycle latency.
